// File: rtl/emmc_ddr8_rx_deserializer.sv
// eMMC 8-bit DDR read-path deserializer: finds the start bit, packs one block into
// 16-bit words, and checks the 16 per-line/per-edge CRC16s plus the end bit.
module emmc_ddr8_rx_deserializer #(
  parameter int BLOCK_BYTES    = 512,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Abort,
  input  logic [7:0]  ReadData_posEdge,
  input  logic [7:0]  ReadData_negEdge,
  output logic [15:0] RxData,
  output logic        RxValid,
  output logic        Busy,
  output logic        Done,
  output logic        CrcError,
  output logic        EndBitError,
  output logic        Timeout
);

  localparam int BCW = $clog2(BLOCK_BYTES) + 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BLOCK_BYTES - 2);
  localparam logic [BCW-1:0] BYTE_TERM = BCW'(BLOCK_BYTES);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_CRC        = 3'd3;
  localparam logic [2:0] ST_ENDBIT     = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  function automatic logic [15:0] crc16_shift(input logic [15:0] c, input logic b);
    crc16_shift = {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  logic [2:0]     state_q, state_d;
  logic [7:0]     pos_q, pos_d;
  logic [7:0]     neg_q, neg_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [15:0]    rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           crc_err_q, crc_err_d;
  logic           end_err_q, end_err_d;
  logic           timeout_q, timeout_d;

  logic           start_accept;
  logic           start_bit;
  logic           crc_clear;
  logic           crc_shift;
  logic [3:0]     crc_idx;
  logic [7:0]     mis_p;
  logic [7:0]     mis_n;

  assign start_accept = (state_q == ST_IDLE) && Start && !Abort;
  assign start_bit    = (pos_q == 8'h00) && (neg_q == 8'h00);
  assign crc_clear    = start_accept;
  assign crc_shift    = (state_q == ST_DATA);
  // CRC cycle k checks computed bit 15-k, i.e. the bitwise complement of k.
  assign crc_idx      = ~bit_cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [15:0] cp_q, cp_d;
      logic [15:0] cn_q, cn_d;

      always_comb begin
        cp_d = cp_q;
        cn_d = cn_q;
        if (crc_clear) begin
          cp_d = '0;
          cn_d = '0;
        end else if (crc_shift) begin
          cp_d = crc16_shift(cp_q, pos_q[gi]);
          cn_d = crc16_shift(cn_q, neg_q[gi]);
        end
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          cp_q <= '0;
          cn_q <= '0;
        end else begin
          cp_q <= cp_d;
          cn_q <= cn_d;
        end
      end

      assign mis_p[gi] = pos_q[gi] ^ cp_q[crc_idx];
      assign mis_n[gi] = neg_q[gi] ^ cn_q[crc_idx];
    end
  endgenerate

  always_comb begin
    pos_d      = ReadData_posEdge;
    neg_d      = ReadData_negEdge;
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = '0;
    rx_valid_d = 1'b0;
    crc_err_d  = crc_err_q;
    end_err_d  = end_err_q;
    timeout_d  = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (start_accept) begin
          state_d    = ST_WAIT_START;
          byte_cnt_d = '0;
          tmo_cnt_d  = '0;
          bit_cnt_d  = '0;
          crc_err_d  = 1'b0;
          end_err_d  = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_WAIT_START: begin
        if (tmo_cnt_q != TMO_LAST) begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
        if (start_bit) begin
          state_d    = ST_DATA;
          byte_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DATA: begin
        rx_valid_d = 1'b1;
        rx_data_d  = {neg_q, pos_q};
        if (byte_cnt_q != BYTE_TERM) begin
          byte_cnt_d = byte_cnt_q + BCW'(2);
        end
        if (byte_cnt_q == BYTE_LAST) begin
          state_d   = ST_CRC;
          bit_cnt_d = '0;
        end
      end
      ST_CRC: begin
        if ((|mis_p) || (|mis_n)) begin
          crc_err_d = 1'b1;
        end
        if (bit_cnt_q == 4'd15) begin
          state_d = ST_ENDBIT;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      ST_ENDBIT: begin
        if (!((pos_q == 8'hFF) && (neg_q == 8'hFF))) begin
          end_err_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort drops the block but leaves the status flags as they were.
    if (Abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      rx_valid_d = 1'b0;
      rx_data_d  = '0;
      crc_err_d  = crc_err_q;
      end_err_d  = end_err_q;
      timeout_d  = timeout_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      neg_q      <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      timeout_q  <= timeout_d;
    end
  end

  // A word still in the output register is withdrawn in the same cycle as Abort.
  assign RxData      = rx_data_q;
  assign RxValid     = rx_valid_q & ~Abort;
  assign Busy        = (state_q != ST_IDLE);
  assign Done        = (state_q == ST_DONE) & ~Abort;
  assign CrcError    = crc_err_q;
  assign EndBitError = end_err_q;
  assign Timeout     = timeout_q;

endmodule

// File: tb/tb_emmc_ddr8_rx_deserializer.sv
// Directed bench for the eMMC DDR8 RX deserializer: nominal, CRC/end-bit errors,
// timeout, pseudo-start, abort and mid-block reset.
module tb_emmc_ddr8_rx_deserializer;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Abort;
  logic [7:0]  ReadData_posEdge;
  logic [7:0]  ReadData_negEdge;
  logic [15:0] RxData;
  logic        RxValid;
  logic        Busy;
  logic        Done;
  logic        CrcError;
  logic        EndBitError;
  logic        Timeout;

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          wcount = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [15:0] words [4096];
  logic [15:0] mp [8];
  logic [15:0] mn [8];

  emmc_ddr8_rx_deserializer #(
    .BLOCK_BYTES   (512),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .Start           (Start),
    .Abort           (Abort),
    .ReadData_posEdge(ReadData_posEdge),
    .ReadData_negEdge(ReadData_negEdge),
    .RxData          (RxData),
    .RxValid         (RxValid),
    .Busy            (Busy),
    .Done            (Done),
    .CrcError        (CrcError),
    .EndBitError     (EndBitError),
    .Timeout         (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (RxValid === 1'b1 && wcount < 4096) begin
      words[wcount] <= RxData;
      wcount        <= wcount + 1;
    end
    if (Done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] p, input logic [7:0] n);
    ReadData_posEdge = p;
    ReadData_negEdge = n;
    @(posedge Clk);
    #1;
  endtask

  task automatic run_block(input int flip_k, input bit pseudo, input int abort_at,
                           input int reset_at, input logic [7:0] endp, input logic [7:0] endn);
    logic [7:0] p;
    logic [7:0] n;
    for (int i = 0; i < 8; i++) begin
      mp[i] = 16'h0000;
      mn[i] = 16'h0000;
    end
    Start = 1'b1;
    step(8'hFF, 8'hFF);
    Start = 1'b0;
    step(8'hFF, 8'hFF);
    if (pseudo) begin
      step(8'h00, 8'h01);
      step(8'hFF, 8'hFF);
    end
    step(8'h00, 8'h00);
    for (int j = 0; j < 256; j++) begin
      p = 8'(2 * j);
      n = 8'(2 * j + 1);
      if (j == abort_at) begin
        chk("pre_abort_rxvalid", RxValid, 1);
        Abort = 1'b1;
        ReadData_posEdge = p;
        ReadData_negEdge = n;
        @(negedge Clk);
        chk("abort_rxvalid_same_cycle", RxValid, 0);
        @(posedge Clk);
        #1;
        Abort = 1'b0;
        chk("abort_idle_next_cycle", Busy, 0);
        repeat (4) step(8'hFF, 8'hFF);
        return;
      end
      if (j == reset_at) begin
        chk("pre_reset_busy", Busy, 1);
        Reset_n = 1'b0;
        #1;
        chk("reset_outputs_zero",
            {RxData, RxValid, Busy, Done, CrcError, EndBitError, Timeout}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        return;
      end
      for (int i = 0; i < 8; i++) begin
        mp[i] = crc_step(mp[i], p[i]);
        mn[i] = crc_step(mn[i], n[i]);
      end
      step(p, n);
    end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 8; i++) begin
        p[i] = mp[i][15 - k];
        n[i] = mn[i][15 - k];
      end
      if (k == flip_k) n[3] = ~n[3];
      step(p, n);
    end
    step(endp, endn);
    repeat (4) step(8'hFF, 8'hFF);
  endtask

  task automatic check_block(input string tag, input int wbase, input int dbase,
                             input logic ecrc, input logic eend);
    int nbadw;
    logic [15:0] expw;
    nbadw = 0;
    chk($sformatf("%s_word_count", tag), wcount - wbase, 256);
    for (int j = 0; j < 256; j++) begin
      expw = {8'(2 * j + 1), 8'(2 * j)};
      if (words[wbase + j] !== expw) nbadw++;
    end
    chk($sformatf("%s_bad_words", tag), nbadw, 0);
    chk($sformatf("%s_first_word", tag), words[wbase], 16'h0100);
    chk($sformatf("%s_last_word", tag), words[wbase + 255], 16'hFFFE);
    chk($sformatf("%s_done_pulses", tag), done_cnt - dbase, 1);
    chk($sformatf("%s_crc_error", tag), CrcError, ecrc);
    chk($sformatf("%s_endbit_error", tag), EndBitError, eend);
    chk($sformatf("%s_timeout", tag), Timeout, 0);
    chk($sformatf("%s_busy_after", tag), Busy, 0);
    $display("block %s checked: words=%0d dones=%0d", tag, wcount - wbase, done_cnt - dbase);
  endtask

  initial begin
    int wb;
    int db;
    int start_cyc;
    Reset_n = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    ReadData_posEdge = 8'hFF;
    ReadData_negEdge = 8'hFF;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_state", {RxData, RxValid, Busy, Done, CrcError, EndBitError, Timeout}, 0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Abort beats Start while idle
    Start = 1'b1;
    Abort = 1'b1;
    step(8'hFF, 8'hFF);
    Start = 1'b0;
    Abort = 1'b0;
    chk("start_abort_same_cycle_idle", Busy, 0);
    step(8'hFF, 8'hFF);

    wb = wcount; db = done_cnt;
    run_block(-1, 1'b0, -1, -1, 8'hFF, 8'hFF);
    check_block("nominal", wb, db, 1'b0, 1'b0);

    wb = wcount; db = done_cnt;
    run_block(5, 1'b0, -1, -1, 8'hFF, 8'hFF);
    check_block("crc_flip", wb, db, 1'b1, 1'b0);

    wb = wcount; db = done_cnt;
    run_block(-1, 1'b0, -1, -1, 8'hFF, 8'hFE);
    check_block("end_bit", wb, db, 1'b0, 1'b1);

    // Timeout: 16-cycle budget, bus idle high
    wb = wcount; db = done_cnt;
    start_cyc = cyc;
    Start = 1'b1;
    step(8'hFF, 8'hFF);
    Start = 1'b0;
    repeat (20) step(8'hFF, 8'hFF);
    chk("timeout_flag", Timeout, 1);
    chk("timeout_done_pulses", done_cnt - db, 1);
    chk("timeout_done_latency", done_cyc - start_cyc, 17);
    chk("timeout_no_rxvalid", wcount - wb, 0);
    chk("timeout_busy_after", Busy, 0);
    $display("timeout checked: latency=%0d", done_cyc - start_cyc);

    wb = wcount; db = done_cnt;
    run_block(-1, 1'b1, -1, -1, 8'hFF, 8'hFF);
    check_block("pseudo_start", wb, db, 1'b0, 1'b0);

    wb = wcount; db = done_cnt;
    run_block(-1, 1'b0, 100, -1, 8'hFF, 8'hFF);
    chk("abort_word_count", wcount - wb, 98);
    chk("abort_no_done", done_cnt - db, 0);
    $display("abort checked: words=%0d", wcount - wb);

    wb = wcount; db = done_cnt;
    run_block(-1, 1'b0, -1, -1, 8'hFF, 8'hFF);
    check_block("after_abort", wb, db, 1'b0, 1'b0);

    wb = wcount; db = done_cnt;
    run_block(-1, 1'b0, -1, 50, 8'hFF, 8'hFF);
    chk("reset_no_done", done_cnt - db, 0);
    $display("mid-block reset checked");

    wb = wcount; db = done_cnt;
    run_block(-1, 1'b0, -1, -1, 8'hFF, 8'hFF);
    check_block("after_reset", wb, db, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
